encoder_8b10b_multilane: RTL

Parametrised multi-lane 8b/10b encoder and the successor to encoder_8b10b. It encodes LANES bytes per SBYTECLK cycle into LANES 10-bit symbols. Running disparity (RD) is carried through the lanes in order and across cycles. It adds a valid handshake, illegal-K detection, alternate D.x.7 handling, a configurable reset disparity and an exported RD. It sits between the link framing logic and the parallel-to-serial stage.

---
 rtl/encoder_8b10b_pkg.sv | 88 ++++++++
 rtl/encoder_8b10b_lane_comb.sv | 46 ++++
 rtl/encoder_8b10b_multilane.sv | 61 ++++++
 3 files changed

// File: rtl/encoder_8b10b_pkg.sv
// Shared 8b/10b constants and sub-block code tables.
// Tables hold the RD- column; the RD+ column is derived by complementing where required.
package encoder_8b10b_pkg;

   localparam logic RD_NEG = 1'b0;
   localparam logic RD_POS = 1'b1;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   localparam logic [5:0] K28_6B_NEG = 6'b001111;

   // abcdei for data EDCBA, RD- column
   function automatic logic [5:0] enc6_neg(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:  c = 6'b100111;
         5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;
         5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;
         5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;
         5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;
         5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;
         5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;
         5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;
         5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;
         5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;
         5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;
         5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;
         5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;
         5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;
         5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;
         5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;
         default: c = 6'b101011;
      endcase
      return c;
   endfunction

   // fghj for data HGF, column for RD- after the 6b sub-block
   function automatic logic [3:0] enc4_neg(input logic [2:0] y, input logic a7);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;
         3'd1: c = 4'b1001;
         3'd2: c = 4'b0101;
         3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;
         3'd5: c = 4'b1010;
         3'd6: c = 4'b0110;
         default: c = a7 ? 4'b0111 : 4'b1110;
      endcase
      return c;
   endfunction

   // K.28.y fghj, column for RD- after the 6b sub-block
   function automatic logic [3:0] k28_enc4_neg(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;
         3'd1: c = 4'b0110;
         3'd2: c = 4'b1010;
         3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;
         3'd5: c = 4'b0101;
         3'd6: c = 4'b1001;
         default: c = 4'b0111;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/encoder_8b10b_lane_comb.sv
// Combinational single-lane 8b/10b encoder: byte, K and RD in; symbol, RD and K error out.
module encoder_8b10b_lane_comb
   import encoder_8b10b_pkg::*;
(
   input  logic [7:0] data,
   input  logic       k,
   input  logic       rd_in,
   output logic [9:0] symbol,
   output logic       rd_out,
   output logic       kerr
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k28, kx7, is_k, a7, rd_mid, unbal6, unbal4, flip4;
   logic [5:0] c6_neg, c6;
   logic [3:0] c4_neg, c4;

   always_comb begin
      x    = data[4:0];
      y    = data[7:5];
      k28  = (x == 5'd28);
      kx7  = (data == K23_7) || (data == K27_7) || (data == K29_7) || (data == K30_7);
      is_k = k && (k28 || kx7);
      // Illegal K falls back to plain data encoding
      kerr = k && !(k28 || kx7);

      c6_neg = (is_k && k28) ? K28_6B_NEG : enc6_neg(x);
      unbal6 = ($countones(c6_neg) != 3);
      c6     = (rd_in && (unbal6 || x == 5'd7)) ? ~c6_neg : c6_neg;
      rd_mid = rd_in ^ unbal6;

      a7 = is_k ? 1'b1 :
           (y == 3'd7) && ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      c4_neg = (is_k && k28) ? k28_enc4_neg(y) : enc4_neg(y, a7);
      unbal4 = ($countones(c4_neg) != 2);
      // K.28 columns always complement; data only for unbalanced and x.3 codes
      flip4  = rd_mid && (unbal4 || y == 3'd3 || (is_k && k28));
      c4     = flip4 ? ~c4_neg : c4_neg;
      rd_out = rd_mid ^ unbal4;

      symbol = {c6, c4};
   end

endmodule

// File: rtl/encoder_8b10b_multilane.sv
// Multi-lane 8b/10b encoder: lanes chained on running disparity, one-cycle registered output.
module encoder_8b10b_multilane
   import encoder_8b10b_pkg::*;
#(
   parameter int unsigned LANES   = 2,
   parameter bit          INIT_RD = 1'b0
) (
   input  logic                  SBYTECLK,
   input  logic                  RESET,
   input  logic                  i_valid,
   input  logic [LANES*8-1:0]    i_data8b,
   input  logic [LANES-1:0]      K,
   output logic                  o_valid,
   output logic [LANES*10-1:0]   o_data10b,
   output logic [LANES-1:0]      o_kerr,
   output logic                  o_rd
);

   logic [LANES:0]        rd_chain;
   logic [LANES*10-1:0]   sym;
   logic [LANES-1:0]      kerr;
   logic                  rd_q, valid_q;
   logic [LANES*10-1:0]   data_q;
   logic [LANES-1:0]      kerr_q;

   assign rd_chain[0] = rd_q;

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      encoder_8b10b_lane_comb u_lane (
         .data   (i_data8b[8*n +: 8]),
         .k      (K[n]),
         .rd_in  (rd_chain[n]),
         .symbol (sym[10*n +: 10]),
         .rd_out (rd_chain[n+1]),
         .kerr   (kerr[n])
      );
   end

   always_ff @(posedge SBYTECLK or posedge RESET) begin
      if (RESET) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         kerr_q  <= '0;
         rd_q    <= INIT_RD;
      end else begin
         valid_q <= i_valid;
         // Idle cycles hold the symbol and consume no disparity
         if (i_valid) begin
            data_q <= sym;
            kerr_q <= kerr;
            rd_q   <= rd_chain[LANES];
         end
      end
   end

   assign o_valid   = valid_q;
   assign o_data10b = data_q;
   assign o_kerr    = kerr_q;
   assign o_rd      = rd_q;

endmodule
